// File: rtl/bnn_weight_streamer_if.sv
// Bus bundle for the BNN weight streamer: byte push handshake, session
// control and the nibble/strobe outputs that drive the BNN weight pins.
interface bnn_weight_streamer_if;
  logic       ena;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] wt_nibble;
  logic       wt_load_en;
  logic       busy;
  logic       done;
  logic [4:0] neuron_idx;
  logic       underrun;
  logic [7:0] checksum;

  // Producer / controller side (drives control and the byte stream)
  modport master (
    output ena, start, in_data, in_valid,
    input  in_ready, wt_nibble, wt_load_en, busy, done,
    input  neuron_idx, underrun, checksum
  );

  // Streamer side
  modport slave (
    input  ena, start, in_data, in_valid,
    output in_ready, wt_nibble, wt_load_en, busy, done,
    output neuron_idx, underrun, checksum
  );
endinterface

// File: rtl/bnn_weight_streamer.sv
// BNN weight streamer: buffers weight bytes in a small FIFO and sends each
// byte to the BNN as two nibbles (low then high) with a load strobe.
// Optional feature macro: BNN_WSTREAM_CHECKSUM_EN -- when defined, a running
// XOR of the bytes sent in the session is kept; otherwise checksum reads 0.
module bnn_weight_streamer #(
  parameter int NUM_NEURONS = 12,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bnn_weight_streamer_if.slave  bus
);
  localparam int         AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [4:0] LAST_IDX = 5'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic [7:0]  head;

  state_t      state_q, state_d;
  logic [3:0]  nibble_q, nibble_d;
  logic        load_en_q, load_en_d;
  logic [4:0]  idx_q, idx_d;
  logic        underrun_q, underrun_d;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign push       = bus.in_valid && !fifo_full;

  // FIFO storage: written on every accepted push, read asynchronously at head.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus.in_data;
    end
  end

  // FIFO pointers; push and pop in the same cycle are both honoured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Next-state and registered-output decode. With ena low everything holds
  // and the strobe is dropped. The FIFO is only popped on the high nibble,
  // so a byte is never split across an empty-FIFO stall.
  always_comb begin
    state_d    = state_q;
    nibble_d   = nibble_q;
    load_en_d  = 1'b0;
    idx_d      = idx_q;
    underrun_d = underrun_q;
    pop        = 1'b0;
    if (bus.ena) begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d    = S_LOW;
            idx_d      = '0;
            underrun_d = 1'b0;
          end
        end
        S_LOW: begin
          if (!fifo_empty) begin
            nibble_d  = head[3:0];
            load_en_d = 1'b1;
            state_d   = S_HIGH;
          end else begin
            underrun_d = 1'b1;
          end
        end
        S_HIGH: begin
          nibble_d  = head[7:4];
          load_en_d = 1'b1;
          pop       = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = S_LOW;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      nibble_q   <= '0;
      load_en_q  <= 1'b0;
      idx_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      nibble_q   <= nibble_d;
      load_en_q  <= load_en_d;
      idx_q      <= idx_d;
      underrun_q <= underrun_d;
    end
  end

`ifdef BNN_WSTREAM_CHECKSUM_EN
  logic [7:0] checksum_q, checksum_d;

  // Running XOR of bytes popped this session; cleared when a session starts.
  always_comb begin
    checksum_d = checksum_q;
    if (bus.ena && (state_q == S_IDLE) && bus.start) begin
      checksum_d = '0;
    end else if (pop) begin
      checksum_d = checksum_q ^ head;
    end
  end

  // Checksum accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign bus.checksum = checksum_q;
`else
  assign bus.checksum = 8'h00;
`endif

  assign bus.in_ready   = !fifo_full;
  assign bus.wt_nibble  = nibble_q;
  assign bus.wt_load_en = load_en_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.neuron_idx = idx_q;
  assign bus.underrun   = underrun_q;
endmodule

// File: tb/tb_bnn_weight_streamer.sv
// Bench for bnn_weight_streamer: random byte streams checked against a
// queue-based model of the expected nibble stream, checksum and timing.
module tb_bnn_weight_streamer;
  localparam int NN    = 12;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;

  bnn_weight_streamer_if bus ();

  bnn_weight_streamer #(.NUM_NEURONS(NN), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  logic [7:0] feed_q[$];
  logic [7:0] model_q[$];
  logic [3:0] obs_nib[$];
  int         obs_cyc[$];
  int         load_cnt = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  bit         feed_en = 1'b0;
  int         gap_pct = 0;
  int         obs_base = 0;
  int         load_base = 0;
  int         start_edge = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle_counter();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  // Byte producer: decides at the falling edge, so a transfer it records
  // in the model happens at the following rising edge.
  task automatic feeder();
    forever begin
      @(negedge clk);
      if (rst_n && feed_en && feed_q.size() > 0 &&
          !(gap_pct > 0 && int'($urandom_range(99)) < gap_pct)) begin
        bus.in_valid = 1'b1;
        bus.in_data  = feed_q[0];
        if (bus.in_ready) model_q.push_back(feed_q.pop_front());
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.wt_load_en) begin
          obs_nib.push_back(bus.wt_nibble);
          obs_cyc.push_back(cyc);
          load_cnt++;
          $display("[%0t] load nibble=%h idx=%0d", $time, bus.wt_nibble, bus.neuron_idx);
        end
        if (bus.done) begin
          done_cnt++;
          done_cyc = cyc;
          $display("[%0t] session done checksum=%02h", $time, bus.checksum);
        end
      end
    end
  endtask

  task automatic queue_random(input int n);
    for (int i = 0; i < n; i++) feed_q.push_back(8'($urandom));
  endtask

  task automatic wait_model(input int n);
    for (int i = 0; i < 100 && model_q.size() < n; i++) @(negedge clk);
    check_eq("prefill", 32'(model_q.size() >= n), 1);
  endtask

  task automatic do_start();
    @(negedge clk);
    bus.ena    = 1'b1;
    bus.start  = 1'b1;
    start_edge = cyc + 1;
    obs_base   = obs_nib.size();
    load_base  = load_cnt;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rand_ena);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
      if (rand_ena) bus.ena = (bus.done || !bus.busy) ? 1'b1 : (($urandom_range(3)) != 0);
    end
    bus.ena = 1'b1;
    check_eq("done_seen", 32'(done_cnt - d0), 1);
  endtask

  // Compare the observed nibble stream of this session with the model bytes.
  task automatic finish_session(input int extra, input bit timing);
    int         nl;
    logic [7:0] b;
    logic [7:0] x;
    @(negedge clk);
    x  = 8'h00;
    nl = obs_nib.size() - obs_base;
    check_eq("load_count", 32'(load_cnt - load_base), 2 * NN);
    check_eq("nibble_count", 32'(nl), 2 * NN);
    for (int k = 0; k < NN; k++) begin
      b = (k < model_q.size()) ? model_q[k] : 8'h00;
      x = x ^ b;
      if (2 * k + 1 < nl) begin
        check_eq($sformatf("lo_nib%0d", k), 32'(obs_nib[obs_base + 2 * k]), 32'(b[3:0]));
        check_eq($sformatf("hi_nib%0d", k), 32'(obs_nib[obs_base + 2 * k + 1]), 32'(b[7:4]));
      end
    end
    if (timing && nl > 0) begin
      check_eq("first_load_latency", 32'(obs_cyc[obs_base] - start_edge), 1);
      check_eq("session_length", 32'(done_cyc - start_edge), 32'(2 * NN + extra));
    end
`ifdef BNN_WSTREAM_CHECKSUM_EN
    check_eq("checksum", 32'(bus.checksum), 32'(x));
`else
    check_eq("checksum", 32'(bus.checksum), 0);
`endif
    check_eq("busy_after", 32'(bus.busy), 0);
    check_eq("done_after", 32'(bus.done), 0);
    for (int k = 0; k < NN && model_q.size() > 0; k++) void'(model_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b1;
    int         d0;
    bus.ena      = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst_n        = 1'b0;
    fork
      cycle_counter();
      feeder();
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_load_en", 32'(bus.wt_load_en), 0);
    check_eq("rst_nibble", 32'(bus.wt_nibble), 0);
    check_eq("rst_idx", 32'(bus.neuron_idx), 0);
    check_eq("rst_underrun", 32'(bus.underrun), 0);
    check_eq("rst_checksum", 32'(bus.checksum), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_done", 32'(bus.done), 0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 1);
    rst_n = 1'b1;

    // Normal session with the fixed prefill bytes
    feed_q.push_back(8'hEB);
    feed_q.push_back(8'h61);
    feed_q.push_back(8'h9F);
    feed_q.push_back(8'hF1);
    feed_en = 1'b1;
    wait_model(4);
    @(negedge clk);
    check_eq("prefill_ready", 32'(bus.in_ready), 32'(model_q.size() < DEPTH));
    queue_random(NN - 4);
    do_start();
    check_eq("start_busy", 32'(bus.busy), 1);
    check_eq("start_idx", 32'(bus.neuron_idx), 0);
    wait_done(200, 1'b0);
    finish_session(0, 1'b1);

    // Full FIFO in IDLE, then a session that keeps refilling it
    queue_random(DEPTH);
    wait_model(DEPTH);
    repeat (3) begin
      @(negedge clk);
      check_eq("full_in_ready", 32'(bus.in_ready), 0);
    end
    queue_random(NN - DEPTH);
    do_start();
    wait_done(200, 1'b0);
    finish_session(0, 1'b1);
    check_eq("drained_in_ready", 32'(bus.in_ready), 1);

    // Starvation: start on an empty FIFO, byte arrives later
    do_start();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("starve_load_en", 32'(bus.wt_load_en), 0);
      check_eq("starve_underrun", 32'(bus.underrun), 1);
    end
    queue_random(NN);
    wait_done(300, 1'b0);
    finish_session(0, 1'b0);
    if (obs_nib.size() - obs_base >= 2)
      check_eq("starve_consecutive", 32'(obs_cyc[obs_base + 1] - obs_cyc[obs_base]), 1);
    check_eq("underrun_sticky", 32'(bus.underrun), 1);

    // ena drop for three cycles while in HIGH
    queue_random(NN);
    wait_model(DEPTH);
    b1 = model_q[1];
    do_start();
    check_eq("underrun_cleared", 32'(bus.underrun), 0);
    repeat (3) @(negedge clk);
    check_eq("pre_drop_nibble", 32'(bus.wt_nibble), 32'(b1[3:0]));
    bus.ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("drop_load_en", 32'(bus.wt_load_en), 0);
      check_eq("drop_nibble", 32'(bus.wt_nibble), 32'(b1[3:0]));
      check_eq("drop_idx", 32'(bus.neuron_idx), 1);
    end
    bus.ena = 1'b1;
    wait_done(200, 1'b0);
    finish_session(3, 1'b1);

    // Back-to-back: start in HIGH is ignored, start in IDLE restarts cleanly
    queue_random(2 * NN);
    wait_model(DEPTH);
    do_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(200, 1'b0);
    finish_session(0, 1'b1);
    do_start();
    check_eq("restart_idx", 32'(bus.neuron_idx), 0);
    check_eq("restart_checksum", 32'(bus.checksum), 0);
    wait_done(200, 1'b0);
    finish_session(0, 1'b1);

    // Reset in the middle of a session
    queue_random(NN);
    wait_model(DEPTH);
    do_start();
    for (int i = 0; i < 100 && bus.neuron_idx != 5'd5; i++) @(negedge clk);
    check_eq("reached_idx5", 32'(bus.neuron_idx), 5);
    #1;
    rst_n   = 1'b0;
    feed_en = 1'b0;
    feed_q.delete();
    model_q.delete();
    #1;
    check_eq("async_load_en", 32'(bus.wt_load_en), 0);
    check_eq("async_busy", 32'(bus.busy), 0);
    d0 = done_cnt;
    @(negedge clk);
    check_eq("mid_rst_nibble", 32'(bus.wt_nibble), 0);
    check_eq("mid_rst_idx", 32'(bus.neuron_idx), 0);
    check_eq("mid_rst_checksum", 32'(bus.checksum), 0);
    check_eq("mid_rst_done", 32'(bus.done), 0);
    check_eq("mid_rst_in_ready", 32'(bus.in_ready), 1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("no_done_after_reset", 32'(done_cnt - d0), 0);
    check_eq("idle_after_reset", 32'(bus.busy), 0);
    feed_en = 1'b1;
    queue_random(NN);
    wait_model(DEPTH);
    do_start();
    wait_done(200, 1'b0);
    finish_session(0, 1'b1);

    // Random sessions with producer gaps and random ena
    gap_pct = 30;
    repeat (3) begin
      queue_random(NN);
      do_start();
      wait_done(800, 1'b1);
      finish_session(0, 1'b0);
    end
    gap_pct = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
